switch_debouncer: RTL and testbench

Per-switch synchronizer and debounce filter that sits directly upstream of the switch-to-LED/7-segment display stage. It takes the raw, asynchronous, bouncing slide-switch levels and produces clean, glitch-free levels on `SW_DB`, which drive the display stage's `SW` input. Optional one-cycle edge pulses per switch are available for downstream event logic.

---
 rtl/switch_debouncer.sv | 90 +++++++++
 tb/tb_switch_debouncer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus per-channel debounce; SW_DB settles STABLE_CYCLES+2 edges after a held raw change, no backpressure.
// Define SWITCH_DEBOUNCER_EDGE_EN to build the registered SW_RISE/SW_FALL pulses; otherwise they are tied to 0.
module switch_debouncer #(
  parameter int WIDTH         = 6,
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [0:WIDTH-1] SW_RAW,
  output logic [0:WIDTH-1] SW_DB,
  output logic [0:WIDTH-1] SW_RISE,
  output logic [0:WIDTH-1] SW_FALL,
  output logic             SW_VALID
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [0:WIDTH-1] sync1;
  logic [0:WIDTH-1] sync2;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [0:WIDTH-1] db_next;
  logic [CNT_W-1:0] start_cnt;
  logic             start_run;

  always_comb begin
    db_next = SW_DB;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (!SW_VALID) begin
        db_next[i] = sync2[i];
      end else if (sync2[i] != SW_DB[i]) begin
        if (cnt[i] == LAST) begin
          db_next[i] = sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // start_run delays the startup count by one edge so SW_VALID rises at edge STABLE_CYCLES+1
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync1     <= '0;
      sync2     <= '0;
      SW_DB     <= '0;
      SW_VALID  <= 1'b0;
      start_cnt <= '0;
      start_run <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= SW_RAW;
      sync2 <= sync1;
      SW_DB <= db_next;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
      if (!SW_VALID) begin
        start_run <= 1'b1;
        if (start_run) begin
          if (start_cnt == LAST) begin
            SW_VALID <= 1'b1;
          end else begin
            start_cnt <= start_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

`ifdef SWITCH_DEBOUNCER_EDGE_EN
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      SW_RISE <= '0;
      SW_FALL <= '0;
    end else begin
      SW_RISE <= SW_VALID ? (db_next & ~SW_DB) : '0;
      SW_FALL <= SW_VALID ? (~db_next & SW_DB) : '0;
    end
  end
`else
  assign SW_RISE = '0;
  assign SW_FALL = '0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: history-window reference model checked every cycle, directed scenarios, random bouncing.
module tb_switch_debouncer;
  localparam int W = 6;
  localparam int S = 4;
`ifdef SWITCH_DEBOUNCER_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         RESET;
  logic [0:W-1] SW_RAW;
  logic [0:W-1] SW_DB;
  logic [0:W-1] SW_RISE;
  logic [0:W-1] SW_FALL;
  logic         SW_VALID;

  int checks = 0;
  int failures = 0;

  switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
    .CLOCK_50(clk),
    .RESET(RESET),
    .SW_RAW(SW_RAW),
    .SW_DB(SW_DB),
    .SW_RISE(SW_RISE),
    .SW_FALL(SW_FALL),
    .SW_VALID(SW_VALID)
  );

  always #5 clk = ~clk;

  // Reference model: raw level seen at each post-reset edge, and the
  // debounced level derived from windows over that history.
  logic [0:W-1] hist[$];
  int           n_edge = 0;
  int           last_chg[W];
  logic [0:W-1] m_db = '0;
  logic [0:W-1] m_rise = '0;
  logic [0:W-1] m_fall = '0;
  logic         m_valid = 1'b0;

  // sync2 level seen by edge n is the raw level sampled at edge n-2
  function automatic logic [0:W-1] s2_at(input int n);
    if (n >= 3) return hist[n-3];
    return '0;
  endfunction

  // a flip at edge n needs S consecutive filtering-mode mismatches since the last flip
  function automatic bit qualifies(input int i);
    logic [0:W-1] v;
    if (n_edge - last_chg[i] < S) return 1'b0;
    for (int j = 0; j < S; j++) begin
      if (n_edge - j < S + 2) return 1'b0;
      v = s2_at(n_edge - j);
      if (v[i] == m_db[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (RESET) begin
      n_edge = 0;
      hist.delete();
      m_db = '0;
      m_rise = '0;
      m_fall = '0;
      m_valid = 1'b0;
      for (int i = 0; i < W; i++) last_chg[i] = -1000;
    end else begin
      n_edge++;
      hist.push_back(SW_RAW);
      m_rise = '0;
      m_fall = '0;
      if (n_edge < S + 2) begin
        m_db = s2_at(n_edge);
      end else begin
        for (int i = 0; i < W; i++) begin
          if (qualifies(i)) begin
            m_db[i] = ~m_db[i];
            last_chg[i] = n_edge;
            if (m_db[i]) m_rise[i] = 1'b1;
            else m_fall[i] = 1'b1;
          end
        end
      end
      m_valid = (n_edge >= S + 1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_db", SW_DB, m_db);
    chk("model_valid", SW_VALID, m_valid);
    chk("model_rise", SW_RISE, EDGE_EN ? m_rise : '0);
    chk("model_fall", SW_FALL, EDGE_EN ? m_fall : '0);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  logic [0:W-1] e;
  logic [0:W-1] base;

  initial begin
    RESET = 1'b1;
    SW_RAW = 6'b111111;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_db", SW_DB, 0);
      chk("rst_valid", SW_VALID, 0);
      chk("rst_pulse", SW_RISE | SW_FALL, 0);
    end
    RESET = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("start_db", SW_DB, (k >= 3) ? 6'b111111 : 6'b000000);
      chk("start_valid", SW_VALID, (k >= 5) ? 1 : 0);
      chk("start_pulse", SW_RISE | SW_FALL, 0);
    end

    // all channels fall together through the filter
    SW_RAW = '0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("fall_db", SW_DB, (k >= 6) ? 6'b000000 : 6'b111111);
      chk("fall_pulse", SW_FALL, (k == 6 && EDGE_EN) ? 6'b111111 : 6'b000000);
    end

    e = '0;
    e[2] = 1'b1;
    SW_RAW = e;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("rise_db", SW_DB, (k >= 6) ? e : '0);
      chk("rise_pulse", SW_RISE, (k == 6 && EDGE_EN) ? e : '0);
      chk("rise_nofall", SW_FALL, 0);
    end

    for (int k = 0; k < 16; k++) begin
      SW_RAW[0] = (k < 8) && (k % 4 < 2);
      tick();
      chk("bounce_db0", SW_DB[0], 0);
      chk("bounce_pulse", SW_RISE | SW_FALL, 0);
    end

    for (int k = 1; k <= 10; k++) begin
      SW_RAW[4] = (k <= 3);
      tick();
      chk("near_db4", SW_DB[4], 0);
      chk("near_pulse", SW_RISE | SW_FALL, 0);
    end
    e = '0;
    e[4] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      SW_RAW[4] = 1'b1;
      tick();
      chk("hold4_db4", SW_DB[4], (k >= 6) ? 1 : 0);
      chk("hold4_rise", SW_RISE, (k == 6 && EDGE_EN) ? e : '0);
    end

    base = '0;
    base[2] = 1'b1;
    base[4] = 1'b1;
    e = '0;
    e[1] = 1'b1;
    e[5] = 1'b1;
    SW_RAW[1] = 1'b1;
    SW_RAW[5] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("simul_db", SW_DB, (k >= 6) ? (base | e) : base);
      chk("simul_rise", SW_RISE, (k == 6 && EDGE_EN) ? e : '0);
    end

    // reset lands while channel 3's counter sits at 2
    SW_RAW[3] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("midrst_db3", SW_DB[3], 0);
    end
    RESET = 1'b1;
    tick();
    chk("midrst_db", SW_DB, 0);
    chk("midrst_valid", SW_VALID, 0);
    RESET = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("restart_db", SW_DB, (k >= 3) ? 6'b011111 : 6'b000000);
      chk("restart_valid", SW_VALID, (k >= 5) ? 1 : 0);
      chk("restart_pulse", SW_RISE | SW_FALL, 0);
    end

    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(0, 5) == 0) SW_RAW[b] = ~SW_RAW[b];
      end
      RESET = ($urandom_range(0, 399) == 0);
      tick();
    end
    RESET = 1'b0;
    repeat (12) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
